// File: rtl/demux_1xn_stripe_pkg.sv
// Shared constants for the 1xN byte-stripe demux: mode encodings, overflow counter
// width and saturation value, and a clog2 helper for parameter-derived widths.
package demux_1xn_stripe_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int              OVF_W   = 16;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  function automatic int clog2(input int value);
    int res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/demux_1xn_stripe_lane_fifo.sv
// Show-ahead lane FIFO: a pushed word is visible on dout one cycle after the push edge.
// Push is ignored when full, pop when empty; full/empty come from the registered count.
module demux_lane_fifo
  import demux_1xn_stripe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int            AW        = clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Empty lanes drive zero so stale entries never leak onto the bus.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/demux_1xn_stripe.sv
// Stripes a valid-qualified word stream across NUM_CH lane FIFOs, round-robin or to sel.
// in_ready uses only the registered full flag of the target lane (no out_ready path).
module demux_1xn_stripe
  import demux_1xn_stripe_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  parameter  int DEPTH  = 4,
  localparam int SW     = clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    mode,
  input  logic [SW-1:0]           sel,
  input  logic                    validIn,
  input  logic [WIDTH-1:0]        In0,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       outValid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [SW-1:0]           rr_ptr,
  output logic [OVF_W-1:0]        overflow_cnt
);

  logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic [SW-1:0]     tgt;
  logic [NUM_CH-1:0] push, empty, full;
  logic              accept;

  assign tgt      = (mode == MODE_FIXED) ? sel : rr_ptr_q;
  // Gate with reset so nothing is offered as accepted while the lanes are held clear.
  assign in_ready = reset_L && !full[tgt];
  assign accept   = validIn && in_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    ovf_d    = ovf_q;
    if (accept && (mode == MODE_RR)) rr_ptr_d = rr_ptr_q + SW'(1);
    if (validIn && !in_ready && (ovf_q != OVF_MAX)) ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr_q <= '0;
      ovf_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rr_ptr       = rr_ptr_q;
  assign overflow_cnt = ovf_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign push[k]     = accept && (tgt == SW'(k));
    assign outValid[k] = !empty[k];

    demux_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_L (reset_L),
      .push    (push[k]),
      .din     (In0),
      .pop     (out_ready[k]),
      .dout    (data_out[k*WIDTH +: WIDTH]),
      .empty   (empty[k]),
      .full    (full[k])
    );
  end

endmodule

// File: tb/tb_demux_1xn_stripe.sv
// Bench for demux_1xn_stripe: table vectors, hand sequences for stall/reset corners,
// and a per-lane scoreboard queue checked on every pop.
module tb_demux_1xn_stripe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_L;
  logic        mode;
  logic [1:0]  sel;
  logic        validIn;
  logic [7:0]  In0;
  logic        in_ready;
  logic [31:0] data_out;
  logic [3:0]  outValid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [15:0] overflow_cnt;

  logic        mode2;
  logic [0:0]  sel2;
  logic        validIn2;
  logic [15:0] In2;
  logic        in_ready2;
  logic [31:0] data_out2;
  logic [1:0]  outValid2;
  logic [1:0]  out_ready2;
  logic [0:0]  rr_ptr2;
  logic [15:0] overflow_cnt2;

  demux_1xn_stripe #(.WIDTH(8), .NUM_CH(4), .DEPTH(4)) dut (
    .clk(clk), .reset_L(reset_L), .mode(mode), .sel(sel), .validIn(validIn), .In0(In0),
    .in_ready(in_ready), .data_out(data_out), .outValid(outValid), .out_ready(out_ready),
    .rr_ptr(rr_ptr), .overflow_cnt(overflow_cnt)
  );

  demux_1xn_stripe #(.WIDTH(16), .NUM_CH(2), .DEPTH(4)) dut16 (
    .clk(clk), .reset_L(reset_L), .mode(mode2), .sel(sel2), .validIn(validIn2), .In0(In2),
    .in_ready(in_ready2), .data_out(data_out2), .outValid(outValid2), .out_ready(out_ready2),
    .rr_ptr(rr_ptr2), .overflow_cnt(overflow_cnt2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model for the 4-lane instance, evaluated on pre-edge values.
  logic [7:0] exp_q [4][$];
  int         m_rr  = 0;
  int         m_ovf = 0;

  always @(negedge clk) begin
    int   t;
    logic er;
    if (!reset_L) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
      m_rr  = 0;
      m_ovf = 0;
    end else begin
      t  = mode ? int'(sel) : m_rr;
      er = (exp_q[t].size() != 4);
      chk("mon_in_ready", 32'(in_ready), 32'(er));
      chk("mon_rr_ptr", 32'(rr_ptr), 32'(m_rr));
      chk("mon_overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
      for (int k = 0; k < 4; k++) begin
        chk("mon_outValid", 32'(outValid[k]), 32'(exp_q[k].size() != 0));
        if (exp_q[k].size() != 0 && out_ready[k]) begin
          chk("mon_pop_data", 32'(data_out[k*8 +: 8]), 32'(exp_q[k][0]));
          void'(exp_q[k].pop_front());
        end
      end
      if (validIn && er) begin
        exp_q[t].push_back(In0);
        if (!mode) m_rr = (m_rr + 1) % 4;
      end else if (validIn && m_ovf != 65535) begin
        m_ovf++;
      end
    end
  end

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic       vld;
    logic [7:0] din;
    logic       exp_rdy;
    logic [1:0] exp_rr;
    logic [3:0] exp_ov;
    logic [7:0] exp_dat;
  } vec_t;

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic v,
                              input logic [7:0] d, input logic rdy, input logic [1:0] rr,
                              input logic [3:0] ov, input logic [7:0] dat);
    vec_t r;
    r.mode = m; r.sel = s; r.vld = v; r.din = d;
    r.exp_rdy = rdy; r.exp_rr = rr; r.exp_ov = ov; r.exp_dat = dat;
    return r;
  endfunction

  vec_t vecs [15];

  task automatic drain();
    out_ready = 4'hF;
    validIn   = 1'b0;
    for (int c = 0; c < 20 && outValid != 4'h0; c++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", 32'(outValid), 32'h0);
  endtask

  initial begin
    int w;

    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1'b0, 2'd0, 1'b1, 8'(8'h10 + i), 1'b1, 2'(i % 4), 4'(1 << (i % 4)), 8'(8'h10 + i));
    vecs[8]  = mk(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 2'd0, 4'b0000, 8'h00);
    vecs[9]  = mk(1'b0, 2'd0, 1'b1, 8'h20, 1'b1, 2'd0, 4'b0001, 8'h20);
    vecs[10] = mk(1'b0, 2'd0, 1'b1, 8'h21, 1'b1, 2'd1, 4'b0010, 8'h21);
    vecs[11] = mk(1'b0, 2'd0, 1'b1, 8'h22, 1'b1, 2'd2, 4'b0100, 8'h22);
    vecs[12] = mk(1'b1, 2'd0, 1'b1, 8'hEE, 1'b1, 2'd3, 4'b0001, 8'hEE);
    vecs[13] = mk(1'b0, 2'd0, 1'b1, 8'hFF, 1'b1, 2'd3, 4'b1000, 8'hFF);
    vecs[14] = mk(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 2'd0, 4'b0000, 8'h00);

    reset_L = 1'b0; mode = 1'b0; sel = '0; validIn = 1'b0; In0 = '0; out_ready = 4'hF;
    mode2 = 1'b0; sel2 = '0; validIn2 = 1'b0; In2 = '0; out_ready2 = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outValid", 32'(outValid), 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_overflow", 32'(overflow_cnt), 32'h0);
    reset_L = 1'b1;

    // Round-robin stream, idle, then mode switch mid-stream.
    for (int i = 0; i < 15; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; validIn = vecs[i].vld; In0 = vecs[i].din;
      out_ready = 4'hF;
      #1;
      chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].exp_rdy));
      chk("vec_rr_ptr", 32'(rr_ptr), 32'(vecs[i].exp_rr));
      @(posedge clk); #1;
      chk("vec_outValid", 32'(outValid), 32'(vecs[i].exp_ov));
      for (int k = 0; k < 4; k++)
        if (vecs[i].exp_ov[k]) chk("vec_data", 32'(data_out[k*8 +: 8]), 32'(vecs[i].exp_dat));
    end
    validIn = 1'b0;
    chk("rr_after_switch", 32'(rr_ptr), 32'h0);

    // 2-lane, 16-bit instance: words alternate lane0/lane1.
    for (int i = 0; i < 4; i++) begin
      In2 = 16'(16'h1000 + i); validIn2 = 1'b1;
      #1;
      chk("w16_in_ready", 32'(in_ready2), 32'h1);
      chk("w16_rr_ptr", 32'(rr_ptr2), 32'(i % 2));
      @(posedge clk); #1;
      chk("w16_outValid", 32'(outValid2), (i == 0) ? 32'h1 : 32'h3);
    end
    validIn2 = 1'b0;
    chk("w16_lane0_head", 32'(data_out2[15:0]), 32'h1000);
    chk("w16_lane1_head", 32'(data_out2[31:16]), 32'h1001);
    out_ready2 = 2'b11;
    @(posedge clk); #1;
    chk("w16_lane0_next", 32'(data_out2[15:0]), 32'h1002);
    chk("w16_lane1_next", 32'(data_out2[31:16]), 32'h1003);
    @(posedge clk); #1;
    chk("w16_empty", 32'(outValid2), 32'h0);
    out_ready2 = 2'b00;

    // Fixed lane 2 under backpressure until full, then release.
    mode = 1'b1; sel = 2'd2; out_ready = 4'b1011; w = 0;
    for (int c = 1; c <= 6; c++) begin
      validIn = 1'b1; In0 = 8'(8'hA0 + w);
      #1;
      chk("t2_in_ready", 32'(in_ready), 32'(c <= 4));
      if (in_ready) w++;
      @(posedge clk); #1;
    end
    chk("t2_overflow", 32'(overflow_cnt), 32'h2);
    chk("t2_outValid", 32'(outValid), 32'h4);
    chk("t2_head_held", 32'(data_out[23:16]), 32'hA0);
    out_ready = 4'hF;
    for (int c = 0; c < 20 && w < 6; c++) begin
      logic acc;
      validIn = 1'b1; In0 = 8'(8'hA0 + w);
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) w++;
    end
    validIn = 1'b0;
    chk("t2_held_accepted", 32'(w), 32'h6);
    drain();

    // Full lane with same-cycle pop: no push that cycle, push the next.
    mode = 1'b1; sel = 2'd0; out_ready = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      validIn = 1'b1; In0 = 8'(8'h30 + i);
      #1;
      chk("t3_fill_rdy", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
    end
    In0 = 8'h55; out_ready = 4'hF;
    #1;
    chk("t3_full_pop_rdy", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    #1;
    chk("t3_next_rdy", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    validIn = 1'b0;
    chk("t3_lane0_valid", 32'(outValid[0]), 32'h1);
    drain();

    // Asynchronous reset with lanes partially full.
    mode = 1'b0; sel = 2'd0; out_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      validIn = 1'b1; In0 = 8'(8'h40 + i);
      @(posedge clk); #1;
    end
    validIn = 1'b0;
    chk("t5_rr_pre", 32'(rr_ptr), 32'h3);
    chk("t5_outValid_pre", 32'(outValid), 32'h7);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t5_async_outValid", 32'(outValid), 32'h0);
    chk("t5_async_data", data_out, 32'h0);
    chk("t5_async_rr", 32'(rr_ptr), 32'h0);
    chk("t5_async_overflow", 32'(overflow_cnt), 32'h0);
    chk("t5_async_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    reset_L = 1'b1; out_ready = 4'hF; validIn = 1'b1; In0 = 8'h77;
    #1;
    chk("t5_post_rdy", 32'(in_ready), 32'h1);
    chk("t5_post_rr", 32'(rr_ptr), 32'h0);
    @(posedge clk); #1;
    validIn = 1'b0;
    chk("t5_post_outValid", 32'(outValid), 32'h1);
    chk("t5_post_data", 32'(data_out[7:0]), 32'h77);
    drain();

    // Long stall on a full lane: counter saturates.
    mode = 1'b1; sel = 2'd3; out_ready = 4'b0111; validIn = 1'b1; In0 = 8'h5A;
    repeat (70004) @(posedge clk);
    #1;
    chk("t6_saturated", 32'(overflow_cnt), 32'hFFFF);
    validIn = 1'b0;
    chk("t6_lane3_valid", 32'(outValid), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
